// File: rtl/simmem_row_timing_unit.sv
// Single-bank DRAM row-buffer timing model: classifies each request as row hit, miss or
// closed-row, waits the modelled latency, then releases the request's internal ID.
module simmem_row_timing_unit #(
  parameter int unsigned IidWidth       = 5,
  parameter int unsigned AddrWidth      = 16,
  parameter int unsigned RowIdWidth     = 8,
  parameter int unsigned DelayWidth     = 6,
  parameter int unsigned HitCntWidth    = 16,
  parameter int unsigned RowHitCost     = 4,
  parameter int unsigned ActivationCost = 1,
  parameter int unsigned PrechargeCost  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [IidWidth-1:0]    req_iid_i,
  input  logic                   close_row_i,
  output logic                   rel_valid_o,
  input  logic                   rel_ready_i,
  output logic [IidWidth-1:0]    rel_iid_o,
  output logic                   rel_row_hit_o,
  output logic [DelayWidth-1:0]  rel_delay_o,
  output logic [HitCntWidth-1:0] hit_cnt_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and payload is held stable while valid is high and ready low.

  localparam int unsigned ClosedCost = ActivationCost + RowHitCost;
  localparam int unsigned MissCost   = PrechargeCost + ActivationCost + RowHitCost;

  localparam logic [DelayWidth-1:0] HitDelay    = DelayWidth'(RowHitCost);
  localparam logic [DelayWidth-1:0] ClosedDelay = DelayWidth'(ClosedCost);
  localparam logic [DelayWidth-1:0] MissDelay   = DelayWidth'(MissCost);

  // The countdown loads d-1 and stops at 1, so every cost must fit and be at least 2.
  if (MissCost >= (1 << DelayWidth) || RowHitCost < 2) begin : g_cost_check
    $error("simmem_row_timing_unit: latency costs do not fit DelayWidth");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state;
  logic                    row_open;
  logic [RowIdWidth-1:0]   open_row;
  logic [DelayWidth-1:0]   cnt;
  logic [IidWidth-1:0]     pend_iid;
  logic                    pend_hit;
  logic [DelayWidth-1:0]   pend_delay;

  logic [RowIdWidth-1:0]   req_row;
  logic                    req_hit;
  logic [DelayWidth-1:0]   req_delay;
  logic                    accept;
  logic                    unused_addr_bits;

  assign req_ready_o      = (state == ST_IDLE) && !rst_i;
  assign rel_valid_o      = (state == ST_DONE);
  assign accept           = req_valid_i && req_ready_o;
  assign unused_addr_bits = ^req_addr_i[AddrWidth-RowIdWidth-1:0];

  always_comb begin
    req_row   = req_addr_i[AddrWidth-1 -: RowIdWidth];
    req_hit   = row_open && (req_row == open_row);
    req_delay = MissDelay;
    if (!row_open) begin
      req_delay = ClosedDelay;
    end else if (req_hit) begin
      req_delay = HitDelay;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      row_open      <= 1'b0;
      open_row      <= '0;
      cnt           <= '0;
      pend_iid      <= '0;
      pend_hit      <= 1'b0;
      pend_delay    <= '0;
      rel_iid_o     <= '0;
      rel_row_hit_o <= 1'b0;
      rel_delay_o   <= '0;
      hit_cnt_o     <= '0;
    end else begin
      // A close on the accepting edge loses to the accept below, which reopens the row.
      if (close_row_i) begin
        row_open <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_open   <= 1'b1;
            open_row   <= req_row;
            pend_iid   <= req_iid_i;
            pend_hit   <= req_hit;
            pend_delay <= req_delay;
            cnt        <= req_delay - DelayWidth'(1);
            state      <= ST_BUSY;
            if (req_hit && (hit_cnt_o != '1)) begin
              hit_cnt_o <= hit_cnt_o + HitCntWidth'(1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt == DelayWidth'(1)) begin
            state         <= ST_DONE;
            rel_iid_o     <= pend_iid;
            rel_row_hit_o <= pend_hit;
            rel_delay_o   <= pend_delay;
          end else begin
            cnt <= cnt - DelayWidth'(1);
          end
        end
        ST_DONE: begin
          if (rel_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_row_timing_unit.sv
// Bench for simmem_row_timing_unit: fixed vector table, reset corner sequences and
// randomized requests checked against a row-buffer reference model.
module tb_simmem_row_timing_unit;

  localparam int IW = 5;
  localparam int AW = 16;
  localparam int DW = 6;
  localparam int HW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [IW-1:0] req_iid_i;
  logic          close_row_i;
  logic          rel_valid_o;
  logic          rel_ready_i;
  logic [IW-1:0] rel_iid_o;
  logic          rel_row_hit_o;
  logic [DW-1:0] rel_delay_o;
  logic [HW-1:0] hit_cnt_o;

  always #5 clk_i = ~clk_i;

  simmem_row_timing_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_iid_i     (req_iid_i),
    .close_row_i   (close_row_i),
    .rel_valid_o   (rel_valid_o),
    .rel_ready_i   (rel_ready_i),
    .rel_iid_o     (rel_iid_o),
    .rel_row_hit_o (rel_row_hit_o),
    .rel_delay_o   (rel_delay_o),
    .hit_cnt_o     (hit_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: which row (if any) is open, and how many hits so far.
  bit m_open;
  int m_row;
  int m_hits;
  int prev_iid, prev_hit, prev_delay;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] iid;
    bit            close_before;
    bit            close_acc;
    bit            close_busy;
    int            bp;
    bit            exp_hit;
    int            exp_d;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_req(input logic [AW-1:0] addr, input bit close_busy,
                                    output bit hit, output int d);
    int row;
    row = int'(addr[AW-1:AW-8]);
    if (!m_open) begin
      hit = 0; d = 1 + 4;
    end else if (row == m_row) begin
      hit = 1; d = 4;
    end else begin
      hit = 0; d = 2 + 1 + 4;
    end
    m_row  = row;
    m_open = !close_busy;
    if (hit && m_hits < 65535) m_hits++;
  endfunction

  task automatic run_req(input logic [AW-1:0] addr, input logic [IW-1:0] iid,
                         input bit close_before, input bit close_acc, input bit close_busy,
                         input int bp, input bit exp_hit, input int exp_d);
    int lat;
    if (close_before) begin
      @(negedge clk_i);
      close_row_i = 1'b1;
      @(negedge clk_i);
      close_row_i = 1'b0;
    end
    @(negedge clk_i);
    check("ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_iid_i   = iid;
    close_row_i = close_acc;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    close_row_i = 1'b0;
    req_addr_i  = AW'($urandom);
    req_iid_i   = IW'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        check("ready_busy", req_ready_o, 0);
        check("hold_iid", rel_iid_o, prev_iid);
        check("hold_hit", rel_row_hit_o, prev_hit);
        check("hold_delay", rel_delay_o, prev_delay);
        close_row_i = close_busy;
      end
      if (k == 2) close_row_i = 1'b0;
      if (rel_valid_o) begin
        lat = k;
        break;
      end
    end
    close_row_i = 1'b0;
    check("latency", lat, exp_d);
    if (lat > 0) begin
      check("rel_iid", rel_iid_o, iid);
      check("rel_hit", rel_row_hit_o, exp_hit);
      check("rel_delay", rel_delay_o, exp_d);
      check("hit_cnt", hit_cnt_o, m_hits);
      check("ready_done", req_ready_o, 0);
      for (int b = 0; b < bp; b++) begin
        @(negedge clk_i);
        check("bp_valid", rel_valid_o, 1);
        check("bp_iid", rel_iid_o, iid);
        check("bp_delay", rel_delay_o, exp_d);
        check("bp_ready", req_ready_o, 0);
      end
      rel_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rel_ready_i = 1'b0;
      @(negedge clk_i);
      check("post_valid", rel_valid_o, 0);
      check("post_ready", req_ready_o, 1);
    end
    prev_iid   = int'(iid);
    prev_hit   = int'(exp_hit);
    prev_delay = exp_d;
  endtask

  initial begin
    bit h;
    int d;
    bit seen;
    logic [7:0] rows [3];
    logic [AW-1:0] a;
    bit cb, ca, cy;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_iid_i = '0;
    close_row_i = 1'b0; rel_ready_i = 1'b0;
    m_open = 0; m_row = 0; m_hits = 0; prev_iid = 0; prev_hit = 0; prev_delay = 0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", req_ready_o, 0);
    check("rst_valid", rel_valid_o, 0);
    check("rst_iid", rel_iid_o, 0);
    check("rst_delay", rel_delay_o, 0);
    check("rst_hitcnt", hit_cnt_o, 0);
    rst_i = 1'b0;
    #1;
    check("rst_ready_after", req_ready_o, 1);

    vecs[0]  = '{16'h1234, 5'd3,  0, 0, 0, 0,  0, 5};
    vecs[1]  = '{16'h12F0, 5'd7,  0, 0, 0, 1,  1, 4};
    vecs[2]  = '{16'h8000, 5'd1,  0, 0, 0, 10, 0, 7};
    vecs[3]  = '{16'h80AA, 5'd2,  0, 0, 0, 0,  1, 4};
    vecs[4]  = '{16'h8011, 5'd4,  1, 0, 0, 2,  0, 5};
    vecs[5]  = '{16'h4000, 5'd5,  0, 1, 0, 0,  0, 7};
    vecs[6]  = '{16'h40FF, 5'd6,  0, 0, 0, 1,  1, 4};
    vecs[7]  = '{16'hFFFF, 5'd31, 0, 0, 0, 0,  0, 7};
    vecs[8]  = '{16'h0000, 5'd0,  0, 0, 0, 3,  0, 7};
    vecs[9]  = '{16'h0001, 5'd9,  0, 0, 1, 0,  1, 4};
    vecs[10] = '{16'h0002, 5'd10, 0, 0, 0, 0,  0, 5};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].close_before) m_open = 0;
      model_req(vecs[i].addr, vecs[i].close_busy, h, d);
      run_req(vecs[i].addr, vecs[i].iid, vecs[i].close_before, vecs[i].close_acc,
              vecs[i].close_busy, vecs[i].bp, vecs[i].exp_hit, vecs[i].exp_d);
    end

    // Reset while BUSY: the in-flight request is dropped and the row closes.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 16'h3000; req_iid_i = 5'd8;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("midrst_ready", req_ready_o, 0);
    check("midrst_valid", rel_valid_o, 0);
    check("midrst_hitcnt", hit_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midrst_ready_after", req_ready_o, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (rel_valid_o) seen = 1;
    end
    check("midrst_no_release", seen, 0);
    m_open = 0; m_hits = 0; prev_iid = 0; prev_hit = 0; prev_delay = 0;
    model_req(16'h3000, 0, h, d);
    run_req(16'h3000, 5'd9, 0, 0, 0, 0, 0, 5);

    // Randomized requests over a few rows so hits, misses and closes all occur.
    rows[0] = 8'h12; rows[1] = 8'h34; rows[2] = 8'h80;
    for (int i = 0; i < 40; i++) begin
      a  = {rows[$urandom_range(0, 2)], 8'($urandom)};
      cb = ($urandom_range(0, 3) == 0);
      ca = ($urandom_range(0, 3) == 0);
      cy = ($urandom_range(0, 3) == 0);
      if (cb) m_open = 0;
      model_req(a, cy, h, d);
      run_req(a, IW'($urandom), cb, ca, cy, $urandom_range(0, 3), h, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
